// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution-stage ALU with valid/ready handshakes on issue and
// result. Single-cycle ops resolve straight into DONE; multu and divu run a
// WIDTH-step shift sequencer over a {hi,lo} accumulator pair.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal_op,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;     // result_hi / product high / remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // result / multiplier-product low / quotient
  logic [WIDTH-1:0] opnd_q, opnd_d; // multiplicand or divisor held for the sequencer
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic             dbz_q, dbz_d;

  logic             accept_s;
  logic             last_iter_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_rem_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;

  // Retiring a result in DONE frees the unit in the same cycle.
  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_s    = in_valid && in_ready;
  assign last_iter_s = (cnt_q == CNT_W'(1'b1));

  assign out_valid   = (state_q == S_DONE);
  assign result      = lo_q;
  assign result_hi   = hi_q;
  assign zero        = zero_q;
  assign illegal_op  = ill_q;
  assign div_by_zero = dbz_q;

  // One shift-add multiply step and one restoring-divide step.
  always_comb begin
    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    div_rem_s  = {hi_q, lo_q[WIDTH-1]};
    div_ge_s   = (div_rem_s >= {1'b0, opnd_q});
    // The partial remainder is always below the divisor, so the shifted value
    // minus the divisor fits WIDTH bits whenever the subtraction is taken.
    div_diff_s = div_rem_s[WIDTH-1:0] - opnd_q;
  end

  // Next-state and datapath update for issue, iteration and retirement.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    dbz_d   = dbz_q;

    if (accept_s) begin
      state_d = S_DONE;
      hi_d    = {WIDTH{1'b0}};
      lo_d    = {WIDTH{1'b0}};
      cnt_d   = CNT_W'(WIDTH);
      ill_d   = 1'b0;
      dbz_d   = 1'b0;
      case (op)
        OP_ADD: lo_d = a + b;
        OP_SUB: lo_d = a - b;
        OP_AND: lo_d = a & b;
        OP_OR:  lo_d = a | b;
        OP_SLT: lo_d = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
        OP_NOR: lo_d = ~(a | b);
        OP_MULTU: begin
          state_d = S_MUL;
          lo_d    = b;
          opnd_d  = a;
        end
        OP_DIVU: begin
          if (b == {WIDTH{1'b0}}) begin
            lo_d  = {WIDTH{1'b1}};
            hi_d  = a;
            dbz_d = 1'b1;
          end else begin
            state_d = S_DIV;
            lo_d    = a;
            opnd_d  = b;
          end
        end
        default: ill_d = 1'b1;
      endcase
      zero_d = (state_d == S_DONE) && (lo_d == {WIDTH{1'b0}});
    end else begin
      case (state_q)
        S_MUL: begin
          // Shift {carry,hi,lo} right: consumed multiplier bit leaves lo.
          hi_d  = mul_sum_s[WIDTH:1];
          lo_d  = {mul_sum_s[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q - CNT_W'(1'b1);
          if (last_iter_s) begin
            state_d = S_DONE;
            zero_d  = (lo_d == {WIDTH{1'b0}});
          end else begin
            state_d = S_MUL;
          end
        end
        S_DIV: begin
          hi_d  = div_ge_s ? div_diff_s : div_rem_s[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], div_ge_s};
          cnt_d = cnt_q - CNT_W'(1'b1);
          if (last_iter_s) begin
            state_d = S_DONE;
            zero_d  = (lo_d == {WIDTH{1'b0}});
          end else begin
            state_d = S_DIV;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder and executes it on two operands.
- Single-cycle ops (add, sub, and, or, slt, nor) complete one cycle after issue.
- Iterative ops (unsigned multiply, unsigned divide) run a shift-based sequencer for WIDTH cycles.
- Valid/ready handshake on both issue and result sides, so the unit can sit behind a stalling pipeline stage.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation this cycle
- op  in  4  operation code: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt (signed), 1100 nor, 1000 multu, 1001 divu
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/imm)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  low result; product low half; quotient
- result_hi  out  WIDTH  product high half; remainder; 0 for single-cycle ops
- zero  out  1  result == 0
- illegal_op  out  1  op not in the list above
- div_by_zero  out  1  divu with b == 0

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - in_ready=1; out_valid=0.
  - result, result_hi, zero, illegal_op and div_by_zero all 0.
  - Reset mid-iteration or mid-DONE discards the operation; no result is emitted.
- Issue handshake:
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - op, a and b are captured at that edge; inputs are don't-care afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue in the cycle a result retires.
- States:
  - IDLE
    - Accepted single-cycle op, illegal op, or divu with b==0: compute, go to DONE.
    - Accepted multu: go to MUL.
    - Accepted divu with b!=0: go to DIV.
    - Iteration counter is loaded to WIDTH.
  - MUL
    - Shift-add, one bit of b per cycle, LSB first.
    - {hi,lo} is a 2*WIDTH accumulator.
    - Go to DONE after exactly WIDTH cycles.
  - DIV
    - Restoring division, one quotient bit per cycle, MSB first.
    - Go to DONE after exactly WIDTH cycles.
  - DONE
    - out_valid=1; outputs held stable until out_ready.
    - out_ready && in_valid: accept the new op, take the same transitions as IDLE (out_valid drops only if the new op is iterative).
    - out_ready && !in_valid: go to IDLE, out_valid=0.
- Latency from the accept edge to out_valid high:
  - Single-cycle, illegal and divide-by-zero: 1 cycle.
  - multu and divu: WIDTH+1 cycles.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow trap.
  - slt: signed compare, result = {WIDTH-1 zeros, a<b}.
  - nor = ~(a|b).
  - multu: unsigned; {result_hi,result} = a*b.
  - divu: result = a/b, result_hi = a%b, both unsigned.
  - result_hi = 0 for all single-cycle ops.
- Divide by zero: result = all ones, result_hi = a, div_by_zero=1, 1-cycle latency.
- Illegal op: result = 0, result_hi = 0, illegal_op=1, zero=1, 1-cycle latency.
- Flags are registered with the result. zero reflects result only (not result_hi). Flags are cleared on the next accepted op.
- out_valid is never asserted in IDLE, MUL or DIV.
- in_valid asserted while busy (MUL/DIV, or DONE without out_ready) is ignored. The issuer must hold the op until in_ready.

Test Plan:
- Single-cycle ops:
  - Input: add a=7 b=5; sub a=5 b=5; slt a=0xFFFFFFFF b=1; nor a=0 b=0.
  - Required: results 12, 0 with zero=1, 1, 0xFFFFFFFF; each out_valid exactly 1 cycle after accept.
- Multiply:
  - Input: multu a=0xFFFFFFFF b=0xFFFFFFFF.
  - Required: result_hi=0xFFFFFFFE, result=0x00000001; out_valid exactly 33 cycles after accept; in_ready=0 throughout MUL.
- Divide:
  - Input: divu a=100 b=7 → result=14, result_hi=2 at 33 cycles.
  - Input: divu a=9 b=0 → result=0xFFFFFFFF, result_hi=9, div_by_zero=1 at 1 cycle.
- Backpressure and back-to-back:
  - Input: hold out_ready=0 for 5 cycles after an add; then raise out_ready with a new sub waiting on in_valid.
  - Required: result stable for all 5 cycles; sub accepted on the retire edge; sub result valid on the next cycle.
- Illegal op and reset:
  - Input: op=0101.
  - Required: illegal_op=1, result=0, zero=1.
  - Input: assert rst_n=0 during the 10th cycle of a multu.
  - Required: out_valid=0 and in_ready=1 immediately; no stale result after release.
